// File: rtl/chip_test_pkg.sv
// Shared types and defaults for the chip tester controller.
// State encoding, error codes and the default slot count live here.
`default_nettype none

package chip_test_pkg;

  localparam int NUM_CHIPS_DEF = 8;
  localparam int CNT_W         = 16;
  localparam int SEL_W         = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_ACK       = 3'd3,
    ST_REPORT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_SLOT    = 2'b10
  } err_e;

endpackage

`default_nettype wire

// File: rtl/chip_test_ctrl_if.sv
// Front-panel and tester-slot signal bundle for chip_test_ctrl.
// The master modport is the controller side; slave is the panel/tester side.
`default_nettype none

interface chip_test_ctrl_if
  import chip_test_pkg::*;
#(
  parameter int NUM_CHIPS = NUM_CHIPS_DEF
);

  logic                 Start;
  logic [SEL_W-1:0]     ChipSel;
  logic [NUM_CHIPS-1:0] Tester_Done;
  logic [NUM_CHIPS-1:0] Tester_RSLT;
  logic [NUM_CHIPS-1:0] Tester_Run;
  logic [NUM_CHIPS-1:0] Tester_Disp;
  logic                 Busy;
  logic                 Result_Valid;
  logic                 Pass;
  logic [1:0]           Err;

  modport master (
    input  Start,
    input  ChipSel,
    input  Tester_Done,
    input  Tester_RSLT,
    output Tester_Run,
    output Tester_Disp,
    output Busy,
    output Result_Valid,
    output Pass,
    output Err
  );

  modport slave (
    output Start,
    output ChipSel,
    output Tester_Done,
    output Tester_RSLT,
    input  Tester_Run,
    input  Tester_Disp,
    input  Busy,
    input  Result_Valid,
    input  Pass,
    input  Err
  );

endinterface

`default_nettype wire

// File: rtl/chip_timeout_ctr.sv
// Cycle counter bounding time spent waiting on a tester.
// expire flags the last permitted cycle (count == TIMEOUT-1) while enabled.
`default_nettype none

module chip_timeout_ctr
  import chip_test_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // clear wins so a state change that also re-enables starts from zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/chip_test_ctrl.sv
// Front-panel controller: launches one tester slot, waits for its verdict,
// acknowledges it and reports pass/fail with an error code.
`default_nettype none

module chip_test_ctrl
  import chip_test_pkg::*;
#(
  parameter int                   NUM_CHIPS    = NUM_CHIPS_DEF,
  parameter logic [NUM_CHIPS-1:0] CHIP_PRESENT = NUM_CHIPS'(1),
  parameter int                   TIMEOUT      = 1024
) (
  input  logic             Clk,
  input  logic             Reset_n,
  chip_test_ctrl_if.master bus
);

  // Slots beyond NUM_CHIPS read as absent so any ChipSel value is safe.
  localparam logic [(1<<SEL_W)-1:0] PRESENT_EXT = (1<<SEL_W)'(CHIP_PRESENT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             pass_q, pass_d;
  err_e             err_q, err_d;
  logic             start_prev_q, start_prev_d;

  logic                 start_edge;
  logic                 slot_ok;
  logic                 done_sel;
  logic                 rslt_sel;
  logic                 ctr_clear;
  logic                 ctr_enable;
  logic                 ctr_expire;
  logic [NUM_CHIPS-1:0] sel_oh;

  assign start_edge = bus.Start && !start_prev_q;
  assign slot_ok    = PRESENT_EXT[bus.ChipSel];
  assign done_sel   = bus.Tester_Done[sel_q];
  assign rslt_sel   = bus.Tester_RSLT[sel_q];
  assign sel_oh     = NUM_CHIPS'(1) << sel_q;
  assign ctr_enable = (state_q == ST_WAIT_DONE) || (state_q == ST_ACK);

  chip_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expire  (ctr_expire)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pass_d       = pass_q;
    err_d        = err_q;
    start_prev_d = bus.Start;
    ctr_clear    = 1'b0;

    case (state_q)
      ST_IDLE, ST_REPORT: begin
        if (start_edge) begin
          sel_d  = bus.ChipSel;
          pass_d = 1'b0;
          if (slot_ok) begin
            err_d   = ERR_NONE;
            state_d = ST_LAUNCH;
          end else begin
            err_d   = ERR_SLOT;
            state_d = ST_REPORT;
          end
        end
      end

      ST_LAUNCH: begin
        ctr_clear = 1'b1;
        state_d   = ST_WAIT_DONE;
      end

      // Done is checked before expire so a verdict on the last cycle counts.
      ST_WAIT_DONE: begin
        if (done_sel) begin
          pass_d    = rslt_sel;
          ctr_clear = 1'b1;
          state_d   = ST_ACK;
        end else if (ctr_expire) begin
          pass_d  = 1'b0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_REPORT;
        end
      end

      ST_ACK: begin
        if (!done_sel) begin
          state_d = ST_REPORT;
        end else if (ctr_expire) begin
          pass_d  = 1'b0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_REPORT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // start_prev resets high so a button held through reset cannot fire.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      pass_q       <= 1'b0;
      err_q        <= ERR_NONE;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign bus.Tester_Run   = (state_q == ST_LAUNCH) ? sel_oh : '0;
  assign bus.Tester_Disp  = (state_q == ST_ACK)    ? sel_oh : '0;
  assign bus.Busy         = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE) ||
                            (state_q == ST_ACK);
  assign bus.Result_Valid = (state_q == ST_REPORT);
  assign bus.Pass         = pass_q;
  assign bus.Err          = err_q;

endmodule

`default_nettype wire

// File: doc/chip_test_ctrl.md
CHIP_TEST_CTRL -- requirements
Module: chip_test_ctrl

Interface
REQ-001 Parameter NUM_CHIPS, default 8, is the number of chip tester slots.
REQ-002 Parameter CHIP_PRESENT, default 8'b0000_0001, is the mask of populated tester slots; bit i set means slot i exists.
REQ-003 Parameter TIMEOUT, default 1024, is the maximum cycles spent in WAIT_DONE or in ACK.
REQ-004 Clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Start  in  1  level from the front-panel run button; only its rising edge acts.
REQ-007 ChipSel  in  3  tester slot to run; sampled on the Start edge.
REQ-008 Tester_Done  in  NUM_CHIPS  Done from each tester.
REQ-009 Tester_RSLT  in  NUM_CHIPS  RSLT from each tester; valid while the matching Done is high.
REQ-010 Tester_Run  out  NUM_CHIPS  one-hot Run to the testers.
REQ-011 Tester_Disp  out  NUM_CHIPS  one-hot DISP_RSLT acknowledge to the testers.
REQ-012 Busy  out  1  high in LAUNCH, WAIT_DONE and ACK.
REQ-013 Result_Valid  out  1  high in REPORT.
REQ-014 Pass  out  1  captured tester verdict; 1 means the chip passed.
REQ-015 Err  out  2  error code: 00 none, 01 timeout, 10 unsupported slot.

Function
REQ-016 States SHALL be IDLE, LAUNCH, WAIT_DONE, ACK and REPORT; Tester_Run, Tester_Disp, Busy and Result_Valid SHALL be decoded from the registered state only.
REQ-017 A Start edge SHALL be Start sampled 1 at an edge after being sampled 0 at the previous edge; the previous sample SHALL reset to 1 so a held button does not fire after reset.
REQ-018 In IDLE or REPORT, a Start edge SHALL latch ChipSel into sel_q, clear Pass and Err, and go to LAUNCH; if CHIP_PRESENT[ChipSel]=0, it SHALL instead set Err=10 and go to REPORT.
REQ-019 A Start edge in LAUNCH, WAIT_DONE or ACK SHALL be ignored.
REQ-020 LAUNCH SHALL last exactly one cycle with Tester_Run[sel_q]=1 and then go to WAIT_DONE; Tester_Run SHALL be 0 in every other state.
REQ-021 In WAIT_DONE, Tester_Done[sel_q]=1 SHALL load Pass from Tester_RSLT[sel_q] and go to ACK; Done and RSLT of slots other than sel_q SHALL be ignored.
REQ-022 ACK SHALL hold Tester_Disp[sel_q]=1 until Tester_Done[sel_q] is sampled 0, then go to REPORT.
REQ-023 A 16-bit counter SHALL clear on entry to WAIT_DONE and to ACK and increment each cycle in those states.
REQ-024 When the counter reaches TIMEOUT-1 without the exit condition, the block SHALL set Err=01 and Pass=0 and go to REPORT.
REQ-025 If Done and the timeout occur in the same cycle, Done SHALL win.
REQ-026 REPORT SHALL hold Pass and Err stable until the next accepted Start edge.
REQ-027 Start-edge-to-Tester_Run latency SHALL be one cycle: Run is high in the cycle after the edge that samples the Start edge.

Reset
REQ-028 While Reset_n=0, the block SHALL be in IDLE with Tester_Run=0, Tester_Disp=0, Busy=0, Result_Valid=0, Pass=0, Err=00, sel_q=0 and counter=0, regardless of clock.
REQ-029 Reset mid-operation SHALL drop Tester_Run and Tester_Disp immediately, and the block SHALL await a new Start edge after release.

Structure
REQ-030 The state enum, the Err code enum and the NUM_CHIPS default SHALL reside in the shared package chip_test_pkg.
REQ-031 The timeout counter SHALL be the sub-module chip_timeout_ctr, with clear, enable and expire ports and TIMEOUT as a parameter.

Verification
REQ-032 Slot 0 tester model raises Done 5 cycles after Run with RSLT=1 -> Run pulses 1 cycle, Disp high until Done falls, then Result_Valid=1, Pass=1, Err=00.
REQ-033 Same test with RSLT=0 -> Pass=0, Err=00; a second Start edge in REPORT reruns the test and clears Pass/Err first.
REQ-034 ChipSel=3 with CHIP_PRESENT=8'h01 -> no Run pulse, REPORT with Err=10.
REQ-035 Tester never raises Done, TIMEOUT=16 -> REPORT after 16 WAIT_DONE cycles with Err=01, Pass=0; then Done stuck high in ACK -> Err=01.
REQ-036 Start held high across reset release, plus a Start toggle while Busy -> no launch from either.
REQ-037 Reset_n pulled low in WAIT_DONE and in ACK -> outputs zero asynchronously; a clean test afterwards passes.
